mac_seq_ctrl: RTL and testbench
===============================

// Module: mac_seq_ctrl
// PURPOSE
//   Sequencer for one time-shared signed mac_unit. Accepts a job (vector length N), then streams N operand pairs.
//   Keeps the running sum in an internal accumulator register and returns one dot-product result per job.
//   Sits between the operand fetch logic and the MAC array result collector.
// PARAMETERS
//   DATA_W  8   operand width (signed)
//   MUL_W   16  product width; must equal 2*DATA_W
//   ACC_W   32  accumulator/result width; must be >= MUL_W
//   LEN_W   8   job length counter width; max job = 2**LEN_W-1 pairs
// PORTS
//   clk         in   1       single clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   start       in   1       job request; sampled only in IDLE
//   len         in   LEN_W   number of operand pairs in job; latched on accepted start
//   busy        out  1       high in RUN and DONE
//   in_valid    in   1       operand pair valid
//   in_ready    out  1       controller accepts pair (high only in RUN)
//   in_a        in   DATA_W  signed operand a
//   in_b        in   DATA_W  signed operand b
//   out_valid   out  1       result valid (high only in DONE)
//   out_ready   in   1       consumer accepts result
//   out_result  out  ACC_W   signed dot-product result
//   out_ovf     out  1       sticky signed-overflow flag for current job
// BEHAVIOUR
//   Reset: asynchronous on rst_n low, any state incl. mid-job; job discarded, no result.
//   - State goes to IDLE; acc, cnt and len_q go to 0.
//   - Outputs: busy, in_ready, out_valid, out_ovf = 0; out_result = 0.
//   FSM: IDLE, RUN, DONE.
//   - IDLE & start & len!=0: latch len_q; clear acc, cnt, ovf; go to RUN.
//   - IDLE & start & len==0: clear acc and ovf; go to DONE (result 0, no operand beats).
//   - start in RUN or DONE: ignored, no queuing.
//   - RUN: in_ready=1. Beat = in_valid & in_ready.
//     On a beat: acc <= mac_unit(in_a, in_b, acc) and cnt++.
//     Beat with cnt==len_q-1: go to DONE.
//     Cycles with in_valid=0 are stalls; state is held.
//   - DONE: out_valid=1; out_result=acc; out_ovf=ovf.
//     Result, flag and state are held while out_ready=0. out_ready=1 -> IDLE.
//     No new start until the cycle after the return to IDLE.
//   Latency and timing:
//   - start accepted -> in_ready high the next cycle.
//   - Last beat -> out_valid high the next cycle.
//   - Zero-length job: out_valid high the cycle after start.
//   - Single-cycle bubble: in_ready=0 in IDLE and DONE; full throughput of 1 pair/clk in RUN.
//   Arithmetic: product is sign-extended to ACC_W before the add.
//   - Overflow on a beat: sign(acc)==sign(prod_ext) and sign(sum)!=sign(acc).
//   - Any overflow sets ovf, which stays set until the next accepted start or reset.
// CONFIGURATION
//   MAC_SAT_EN defined:
//   - On an overflowing beat, acc clamps to +(2**(ACC_W-1)-1) or -2**(ACC_W-1), per the sign of the operands.
//   - Later beats accumulate from the clamped value.
//   MAC_SAT_EN undefined: acc wraps modulo 2**ACC_W. out_ovf behaves the same in both builds.
// TESTING
//   1 len=4; pairs (1,2),(3,4),(-5,6),(7,-8), no stalls -> out_valid 1 clk after 4th beat; out_result=-72; out_ovf=0.
//   2 len=0 start -> in_ready never high; out_valid next clk; out_result=0; out_ovf=0.
//   3 Backpressure:
//     - Setup: len=3, in_valid gaps between beats, (2,3)x3.
//     - Stimulus: out_ready low 5 clks, and start pulsed during DONE.
//     - Response: out_result=18 held stable; start ignored; IDLE 1 clk after out_ready.
//   4 ACC_W=16 override; len=3; pairs (127,127)x3 -> out_ovf=1.
//     - out_result=-17149 without MAC_SAT_EN.
//     - out_result=32767 with MAC_SAT_EN.
//   5 Reset mid-job:
//     - Stimulus: len=4, rst_n low after 2 beats.
//     - Required: all outputs 0 immediately (async); no out_valid.
//     - Then: new job len=1, (-128,-128) -> out_result=16384.
//   6 len=255, all pairs (-1,1) back-to-back -> out_valid exactly 256 clks after start accepted; out_result=-255.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
`timescale 1ns/1ps
// mac_seq_ctrl: job sequencer around one time-shared signed multiply-accumulate.
// A job of len operand pairs is streamed in and one signed dot product is returned per job.
// Build option: define MAC_SAT_EN to clamp the accumulator on signed overflow; by default it wraps.
module mac_seq_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MUL_W  = 16,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_result,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic signed [MUL_W-1:0] a_ext;
    logic signed [MUL_W-1:0] b_ext;
    logic signed [MUL_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_s;
    logic signed [ACC_W-1:0] sum;
    logic [ACC_W-1:0]        mac_res;
    logic                    mac_ovf;
    logic                    beat_c;
    logic                    last_beat_c;

    // MAC datapath: signed product, sign-extended add, overflow detect and optional clamp
    always_comb begin
        a_ext    = MUL_W'($signed(in_a));
        b_ext    = MUL_W'($signed(in_b));
        prod     = a_ext * b_ext;
        prod_ext = ACC_W'(prod);
        acc_s    = $signed(acc_q);
        sum      = acc_s + prod_ext;
        mac_ovf  = (acc_s[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_s[ACC_W-1]);
`ifdef MAC_SAT_EN
        if (mac_ovf) begin
            // both addends share a sign, so the accumulator sign picks the rail
            mac_res = acc_s[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            mac_res = sum;
        end
`else
        mac_res = sum;
`endif
    end

    assign beat_c      = in_valid & in_ready_q;
    assign last_beat_c = (cnt_q == LEN_W'(len_q - 1'b1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and accumulator/counter update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    len_d   = len;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (beat_c) begin
                    acc_d = mac_res;
                    cnt_d = LEN_W'(cnt_q + 1'b1);
                    if (mac_ovf) begin
                        ovf_d = 1'b1;
                    end
                    if (last_beat_c) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the next state so they leave a flop
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_RUN);
        out_valid_d = (state_d == S_DONE);
    end

    assign busy       = busy_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = acc_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for mac_seq_ctrl: vector table plus hand-written corner sequences,
// results matched through a scoreboard queue.
module tb_mac_seq_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned ACC_W_S = 16;
    localparam int          NV      = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit accumulator instance
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_result;
    logic              out_ovf;

    // 16-bit accumulator instance
    logic               start_s = 1'b0;
    logic [LEN_W-1:0]   len_s = '0;
    logic               busy_s;
    logic               in_valid_s = 1'b0;
    logic               in_ready_s;
    logic [DATA_W-1:0]  in_a_s = '0;
    logic [DATA_W-1:0]  in_b_s = '0;
    logic               out_valid_s;
    logic               out_ready_s = 1'b1;
    logic [ACC_W_S-1:0] out_result_s;
    logic               out_ovf_s;

    mac_seq_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf)
    );

    mac_seq_ctrl #(.ACC_W(ACC_W_S)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .len(len_s), .busy(busy_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .in_a(in_a_s), .in_b(in_b_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .out_result(out_result_s), .out_ovf(out_ovf_s)
    );

    typedef struct {
        int          len;
        int          gap;
        logic [31:0] a_v;
        logic [31:0] b_v;
        longint      exp_res;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        longint res;
        bit     ovf;
    } exp_t;

    vec_t vecs[NV];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard on every completed result handshake
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_result", $signed(out_result), e.res);
                check("sb_ovf", out_ovf, e.ovf);
            end
        end
    end

    task automatic start_job(input int l, input bit push, input longint r, input bit o);
        exp_t e;
        if (push) begin
            e.res = r;
            e.ovf = o;
            sb_q.push_back(e);
        end
        start = 1'b1;
        len   = LEN_W'(l);
        @(negedge clk);
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_in_ready", in_ready, (l != 0));
        check("accept_out_valid", out_valid, (l == 0));
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cnt;

        vecs[0] = '{len: 4, gap: 0, a_v: 32'h07FB0301, b_v: 32'hF8060402, exp_res: -72,    exp_ovf: 1'b0};
        vecs[1] = '{len: 0, gap: 0, a_v: 32'h00000000, b_v: 32'h00000000, exp_res: 0,      exp_ovf: 1'b0};
        vecs[2] = '{len: 2, gap: 1, a_v: 32'h00008080, b_v: 32'h00007F80, exp_res: 128,    exp_ovf: 1'b0};
        vecs[3] = '{len: 1, gap: 0, a_v: 32'h0000007F, b_v: 32'h00000080, exp_res: -16256, exp_ovf: 1'b0};
        vecs[4] = '{len: 3, gap: 2, a_v: 32'h001EEC0A, b_v: 32'h00FF0A0A, exp_res: -130,   exp_ovf: 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_ovf", out_ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven jobs
        for (int i = 0; i < NV; i++) begin
            start_job(vecs[i].len, 1'b1, vecs[i].exp_res, vecs[i].exp_ovf);
            for (int p = 0; p < vecs[i].len; p++) begin
                send_pair(vecs[i].a_v[8*p +: 8], vecs[i].b_v[8*p +: 8], vecs[i].gap);
            end
            in_valid = 1'b0;
            check("out_valid_after_last", out_valid, 1);
            check("done_in_ready", in_ready, 0);
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_out_valid", out_valid, 0);
        end

        // backpressure with start pulsed during DONE
        out_ready = 1'b0;
        start_job(3, 1'b1, 18, 1'b0);
        for (int p = 0; p < 3; p++) send_pair(8'd2, 8'd3, 2);
        in_valid = 1'b0;
        check("bp_out_valid_rise", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            len   = 8'd2;
            check("bp_out_valid", out_valid, 1);
            check("bp_result", $signed(out_result), 18);
            check("bp_in_ready", in_ready, 0);
            check("bp_busy", busy, 1);
            @(negedge clk);
        end
        start = 1'b0;
        check("bp_still_done", out_valid, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_idle_out_valid", out_valid, 0);
        @(negedge clk);
        check("bp_start_not_queued", busy, 0);

        // reset in the middle of a job
        start_job(4, 1'b0, 0, 1'b0);
        send_pair(8'd5, 8'd5, 0);
        send_pair(8'd5, 8'd5, 0);
        check("pre_reset_result", $signed(out_result), 50);
        check("pre_reset_in_ready", in_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_ovf", out_ovf, 0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_out_valid", out_valid, 0);
        start_job(1, 1'b1, 16384, 1'b0);
        send_pair(8'h80, 8'h80, 0);
        in_valid = 1'b0;
        check("post_rst_out_valid_rise", out_valid, 1);
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        // maximum length job, back-to-back
        begin
            exp_t e;
            e.res = -255;
            e.ovf = 1'b0;
            sb_q.push_back(e);
        end
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'h01;
        start    = 1'b1;
        len      = 8'd255;
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        while (!out_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        check("len255_latency", cnt, 256);
        @(negedge clk);
        check("len255_idle", busy, 0);

        // 16-bit accumulator overflow
        start_s = 1'b1;
        len_s   = 8'd3;
        @(negedge clk);
        start_s = 1'b0;
        check("s_in_ready", in_ready_s, 1);
        in_valid_s = 1'b1;
        in_a_s     = 8'h7F;
        in_b_s     = 8'h7F;
        repeat (3) @(negedge clk);
        in_valid_s = 1'b0;
        check("s_out_valid", out_valid_s, 1);
`ifdef MAC_SAT_EN
        check("s_result", $signed(out_result_s), 32767);
`else
        check("s_result", $signed(out_result_s), -17149);
`endif
        check("s_ovf", out_ovf_s, 1);
        @(negedge clk);
        check("s_idle", busy_s, 0);
        check("s_ovf_sticky", out_ovf_s, 1);
        start_s = 1'b1;
        len_s   = 8'd1;
        @(negedge clk);
        start_s = 1'b0;
        check("s_ovf_cleared", out_ovf_s, 0);
        check("s_acc_cleared", out_result_s, 0);
        in_valid_s = 1'b1;
        in_a_s     = 8'd1;
        in_b_s     = 8'd1;
        @(negedge clk);
        in_valid_s = 1'b0;
        check("s2_out_valid", out_valid_s, 1);
        check("s2_result", $signed(out_result_s), 1);
        check("s2_ovf", out_ovf_s, 0);
        @(negedge clk);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
